// File: rtl/cv_hdmi2lb.sv
// cv_hdmi2lb: TMDS symbol decoder feeding a two-bank (ping-pong) line buffer.
// Front end registers the three TMDS channels, then decodes control/data symbols.
// A lock/blank/active tracker packs RGB555 pixels four to a 64-bit word, flushes
// partial words at end of line, sequences line parity per frame and drops lock
// after a run of symbol errors.
// Build option: CV_HDMI2LB_ERRCNT_EN enables the saturating err_count output.
module cv_hdmi2lb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hdmi_r,
  input  logic [9:0]  hdmi_g,
  input  logic [9:0]  hdmi_b,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic [9:0]  l_wraddr,
  output logic        l_wen,
  output logic [63:0] l_wrdata,
  output logic        line_done,
  output logic [10:0] line_len,
  output logic        frame_start,
  output logic [7:0]  err_count
);

  localparam logic [9:0] Ctl00 = 10'b1101010100;
  localparam logic [9:0] Ctl01 = 10'b0010101011;
  localparam logic [9:0] Ctl10 = 10'b0101010100;
  localparam logic [9:0] Ctl11 = 10'b1010101011;

  typedef enum logic [1:0] {StUnlocked, StBlank, StActive} state_e;

  function automatic logic is_ctrl(input logic [9:0] s);
    return (s == Ctl00) || (s == Ctl01) || (s == Ctl10) || (s == Ctl11);
  endfunction

  // Returns {v, h} carried by a control symbol.
  function automatic logic [1:0] ctrl_code(input logic [9:0] s);
    logic [1:0] c;
    case (s)
      Ctl01:   c = 2'b01;
      Ctl10:   c = 2'b10;
      Ctl11:   c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Only decoded bits [7:3] survive RGB555 packing, so only those are produced.
  // raw holds symbol bits [7:2]; inv is bit 9, xr is bit 8.
  function automatic logic [4:0] tmds_hi(input logic inv, input logic xr,
                                         input logic [5:0] raw);
    logic [5:0] q;
    logic [4:0] d;
    q = inv ? ~raw : raw;
    for (int i = 1; i < 6; i++) begin
      d[i-1] = xr ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Stage 1 / stage 2 pipeline registers
  logic [9:0]  sym_r_q, sym_g_q, sym_b_q;
  logic        ctl_r_q, ctl_g_q, ctl_b_q, ctl_r_d, ctl_g_d, ctl_b_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [15:0] pix_q, pix_d;
  logic        de_prev_q, vs_prev_q;

  // Line/frame state
  state_e      state_q, state_d;
  logic [2:0]  lock_cnt_q, lock_cnt_d;
  logic [47:0] lanes_q, lanes_d;
  logic [1:0]  lane_cnt_q, lane_cnt_d;
  logic [8:0]  word_idx_q, word_idx_d;
  logic        full_q, full_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [9:0]  waddr_q, waddr_d;
  logic        done_pend_q, done_pend_d;
  logic        line_done_q, line_done_d;
  logic [10:0] line_len_q, line_len_d;
  logic        parity_q, parity_d;
  logic        vclr_pend_q, vclr_pend_d;
  logic [2:0]  err_run_q, err_run_d;

  logic de_rise, vs_rise, err, lose_lock;
  logic entry, capture, flush;

  assign de_rise = de_q & ~de_prev_q;
  assign vs_rise = vs_q & ~vs_prev_q;

  // Stage-2 decode of the registered symbols; sync bits hold on data symbols
  always_comb begin
    ctl_r_d = is_ctrl(sym_r_q);
    ctl_g_d = is_ctrl(sym_g_q);
    ctl_b_d = is_ctrl(sym_b_q);
    de_d    = ~ctl_b_d;
    vs_d    = vs_q;
    hs_d    = hs_q;
    if (ctl_b_d) begin
      {vs_d, hs_d} = ctrl_code(sym_b_q);
    end
    pix_d = {1'b0,
             tmds_hi(sym_r_q[9], sym_r_q[8], sym_r_q[7:2]),
             tmds_hi(sym_g_q[9], sym_g_q[8], sym_g_q[7:2]),
             tmds_hi(sym_b_q[9], sym_b_q[8], sym_b_q[7:2])};
  end

  // Input register and decode register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_r_q   <= '0;
      sym_g_q   <= '0;
      sym_b_q   <= '0;
      ctl_r_q   <= 1'b0;
      ctl_g_q   <= 1'b0;
      ctl_b_q   <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_q     <= '0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      sym_r_q   <= hdmi_r;
      sym_g_q   <= hdmi_g;
      sym_b_q   <= hdmi_b;
      ctl_r_q   <= ctl_r_d;
      ctl_g_q   <= ctl_g_d;
      ctl_b_q   <= ctl_b_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      pix_q     <= pix_d;
      de_prev_q <= de_q;
      vs_prev_q <= vs_q;
    end
  end

  // Symbol-error classification and consecutive-error run length
  always_comb begin
    err = ((state_q == StBlank) && ctl_b_q && !(ctl_r_q && ctl_g_q)) ||
          ((state_q == StActive) && !ctl_b_q && (ctl_r_q || ctl_g_q));
    lose_lock = err && (err_run_q == 3'd3);
    err_run_d = 3'd0;
    if (err) begin
      err_run_d = (err_run_q == 3'd7) ? err_run_q : err_run_q + 3'd1;
    end
  end

  // Next-state: lock tracking, pixel packing, flush, line and frame sequencing
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    lanes_d     = lanes_q;
    lane_cnt_d  = lane_cnt_q;
    word_idx_d  = word_idx_q;
    full_d      = full_q;
    pix_cnt_d   = pix_cnt_q;
    wen_d       = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    done_pend_d = 1'b0;
    line_done_d = 1'b0;
    line_len_d  = line_len_q;
    parity_d    = parity_q;
    vclr_pend_d = vclr_pend_q;
    entry       = 1'b0;
    capture     = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      StUnlocked: begin
        if (ctl_r_q && ctl_g_q && ctl_b_q) begin
          if (lock_cnt_q == 3'd7) begin
            state_d    = StBlank;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 3'd1;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      StBlank: begin
        if (de_rise) begin
          state_d = StActive;
          entry   = 1'b1;
          capture = 1'b1;
        end
      end
      StActive: begin
        if (de_q) begin
          capture = 1'b1;
        end else begin
          state_d = StBlank;
          flush   = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase

    // Loss of lock abandons any line in progress without a flush.
    if (lose_lock) begin
      state_d    = StUnlocked;
      lock_cnt_d = '0;
      entry      = 1'b0;
      capture    = 1'b0;
      flush      = 1'b0;
    end

    if (entry) begin
      lanes_d    = '0;
      lane_cnt_d = '0;
      word_idx_d = '0;
      full_d     = 1'b0;
      pix_cnt_d  = '0;
    end

    if (capture) begin
      if (pix_cnt_d != 11'h7FF) begin
        pix_cnt_d = pix_cnt_d + 11'd1;
      end
      if (lane_cnt_d == 2'd3) begin
        if (!full_d) begin
          wen_d   = 1'b1;
          wdata_d = {pix_q, lanes_d};
          waddr_d = {parity_q, word_idx_d};
        end
        lanes_d    = '0;
        lane_cnt_d = '0;
      end else begin
        case (lane_cnt_d)
          2'd0:    lanes_d[15:0]  = pix_q;
          2'd1:    lanes_d[31:16] = pix_q;
          default: lanes_d[47:32] = pix_q;
        endcase
        lane_cnt_d = lane_cnt_d + 2'd1;
      end
    end

    if (flush) begin
      if ((lane_cnt_q != 2'd0) && !full_q) begin
        wen_d       = 1'b1;
        wdata_d     = {16'h0000, lanes_q};
        waddr_d     = {parity_q, word_idx_q};
        done_pend_d = 1'b1;
      end else begin
        line_done_d = 1'b1;
      end
      lanes_d    = '0;
      lane_cnt_d = '0;
      line_len_d = pix_cnt_q;
    end

    // Word index sticks at 511; the write there sets full and blocks later writes.
    if (wen_d) begin
      if (word_idx_d == 9'h1FF) begin
        full_d = 1'b1;
      end else begin
        word_idx_d = word_idx_d + 9'd1;
      end
    end

    if (done_pend_q) begin
      line_done_d = 1'b1;
    end
    if (line_done_d) begin
      parity_d = ~parity_q;
    end

    // A vsync arriving while a line is still closing waits for its line_done.
    if (vs_rise) begin
      if ((state_q == StActive) || done_pend_q) begin
        vclr_pend_d = 1'b1;
      end else begin
        parity_d = 1'b0;
      end
    end
    if (line_done_q && vclr_pend_q) begin
      parity_d    = 1'b0;
      vclr_pend_d = 1'b0;
    end
  end

  // Line/frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StUnlocked;
      lock_cnt_q  <= '0;
      lanes_q     <= '0;
      lane_cnt_q  <= '0;
      word_idx_q  <= '0;
      full_q      <= 1'b0;
      pix_cnt_q   <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      done_pend_q <= 1'b0;
      line_done_q <= 1'b0;
      line_len_q  <= '0;
      parity_q    <= 1'b0;
      vclr_pend_q <= 1'b0;
      err_run_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      lanes_q     <= lanes_d;
      lane_cnt_q  <= lane_cnt_d;
      word_idx_q  <= word_idx_d;
      full_q      <= full_d;
      pix_cnt_q   <= pix_cnt_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      done_pend_q <= done_pend_d;
      line_done_q <= line_done_d;
      line_len_q  <= line_len_d;
      parity_q    <= parity_d;
      vclr_pend_q <= vclr_pend_d;
      err_run_q   <= err_run_d;
    end
  end

`ifdef CV_HDMI2LB_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of error cycles, cleared only by reset
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign l_wraddr    = waddr_q;
  assign l_wen       = wen_q;
  assign l_wrdata    = wdata_q;
  assign line_done   = line_done_q;
  assign line_len    = line_len_q;
  assign frame_start = vs_q & ~vs_prev_q;

endmodule

// File: tb/tb_cv_hdmi2lb.sv
// Directed bench for cv_hdmi2lb: lock, full/partial lines, vsync sequencing,
// loss of lock on errors, word-index saturation and mid-line reset.
`timescale 1ns/1ps
module tb_cv_hdmi2lb;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  // Data symbols (bit9=0, bit8=1): decode to 0x00, 0xF8, 0x08.
  localparam logic [9:0] D00 = 10'h100;
  localparam logic [9:0] DF8 = 10'h1A8;
  localparam logic [9:0] D08 = 10'h1F8;
`ifdef CV_HDMI2LB_ERRCNT_EN
  localparam logic [7:0] ErrExp = 8'd4;
`else
  localparam logic [7:0] ErrExp = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  hdmi_r, hdmi_g, hdmi_b;
  logic        h_sync, v_sync, de, l_wen, line_done, frame_start;
  logic [9:0]  l_wraddr;
  logic [63:0] l_wrdata;
  logic [10:0] line_len;
  logic [7:0]  err_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs_total = 0;
  logic [9:0]  wr_addr[$];
  logic [63:0] wr_data[$];
  int          wr_cyc[$];
  int          ld_cyc[$];
  logic [10:0] ld_len[$];

  cv_hdmi2lb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hdmi_r     (hdmi_r),
    .hdmi_g     (hdmi_g),
    .hdmi_b     (hdmi_b),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .de         (de),
    .l_wraddr   (l_wraddr),
    .l_wen      (l_wen),
    .l_wrdata   (l_wrdata),
    .line_done  (line_done),
    .line_len   (line_len),
    .frame_start(frame_start),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Record write strobes, line_done pulses and frame_start pulses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (l_wen) begin
      wr_addr.push_back(l_wraddr);
      wr_data.push_back(l_wrdata);
      wr_cyc.push_back(cyc);
    end
    if (line_done) begin
      ld_cyc.push_back(cyc);
      ld_len.push_back(line_len);
    end
    if (frame_start) fs_total <= fs_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] wa(input int i);
    return (i >= 0 && i < wr_addr.size()) ? wr_addr[i] : 10'hx;
  endfunction

  function automatic logic [63:0] wd(input int i);
    return (i >= 0 && i < wr_data.size()) ? wr_data[i] : 64'hx;
  endfunction

  function automatic int wc(input int i);
    return (i >= 0 && i < wr_cyc.size()) ? wr_cyc[i] : -100;
  endfunction

  function automatic int lc(input int i);
    return (i >= 0 && i < ld_cyc.size()) ? ld_cyc[i] : -200;
  endfunction

  function automatic logic [10:0] ll(input int i);
    return (i >= 0 && i < ld_len.size()) ? ld_len[i] : 11'hx;
  endfunction

  task automatic step(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    hdmi_r = r;
    hdmi_g = g;
    hdmi_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [9:0] r, input logic [9:0] g,
                     input logic [9:0] b);
    for (int i = 0; i < n; i++) step(r, g, b);
  endtask

  initial begin
    int wb, lb, fb;
    reset_n = 1'b0;
    hdmi_r = C00;
    hdmi_g = C00;
    hdmi_b = C00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {h_sync, v_sync, de, l_wen, line_done, frame_start}, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_err_count", err_count, 0);
    reset_n = 1'b1;

    // Lock, then a 640-pixel line of zeros.
    run(12, C00, C00, C00);
    chk("blank_sync", {h_sync, v_sync, de}, 3'b000);
    wb = wr_addr.size();
    lb = ld_cyc.size();
    step(D00, D00, D00);
    chk("de_lat1", de, 1'b0);
    step(D00, D00, D00);
    chk("de_lat2", de, 1'b1);
    run(638, D00, D00, D00);
    run(6, C00, C00, C00);
    chk("l640_writes", wr_addr.size() - wb, 160);
    chk("l640_first_addr", wa(wb), 10'h000);
    chk("l640_last_addr", wa(wb + 159), 10'h09F);
    chk("l640_last_data", wd(wb + 159), 64'h0);
    chk("l640_done_cnt", ld_cyc.size() - lb, 1);
    chk("l640_len", ll(lb), 11'd640);
    chk("l640_done_timing", lc(lb), wc(wb + 159) + 1);
    chk("l640_err_none", err_count, 8'd0);

    // Vertical sync in blanking.
    fb = fs_total;
    step(C00, C00, C10);
    step(C00, C00, C11);
    chk("vs_rise_vsync", {v_sync, h_sync}, 2'b10);
    chk("vs_rise_fs", frame_start, 1'b1);
    step(C00, C00, C11);
    chk("vs_hs11", {v_sync, h_sync}, 2'b11);
    chk("vs_fs_pulse", frame_start, 1'b0);
    run(6, C00, C00, C01);
    chk("hs_only", {v_sync, h_sync}, 2'b01);
    chk("vs_fs_count", fs_total - fb, 1);

    // 5-pixel line after vsync; ends with vsync rising together with de falling.
    wb = wr_addr.size();
    lb = ld_cyc.size();
    fb = fs_total;
    run(5, DF8, D00, D08);
    chk("hs_hold_in_line", {h_sync, de}, 2'b11);
    step(C00, C00, C10);
    run(6, C00, C00, C00);
    chk("l5_writes", wr_addr.size() - wb, 2);
    chk("l5_addr0", wa(wb), 10'h000);
    chk("l5_data0", wd(wb), 64'h7C017C017C017C01);
    chk("l5_addr1", wa(wb + 1), 10'h001);
    chk("l5_data1", wd(wb + 1), 64'h0000000000007C01);
    chk("l5_len", ll(lb), 11'd5);
    chk("l5_done_timing", lc(lb), wc(wb + 1) + 1);
    chk("l5_fs_count", fs_total - fb, 1);

    // Parity toggled by that line_done then cleared by the deferred vsync.
    wb = wr_addr.size();
    run(4, D00, D00, D00);
    run(6, C00, C00, C00);
    chk("l4_writes", wr_addr.size() - wb, 1);
    chk("l4_addr", wa(wb), 10'h000);

    // Red data while blue control: 4 error cycles drop lock.
    run(4, D00, C00, C00);
    run(7, C00, C00, C00);
    chk("err_count", err_count, ErrExp);
    wb = wr_addr.size();
    lb = ld_cyc.size();
    run(8, D00, D00, D00);
    run(4, C00, C00, C00);
    chk("unlock_no_wen", wr_addr.size() - wb, 0);
    chk("unlock_no_done", ld_cyc.size() - lb, 0);
    run(12, C00, C00, C00);
    chk("err_count_hold", err_count, ErrExp);

    // 2100-pixel line: writes stop at word 511, length saturates.
    wb = wr_addr.size();
    lb = ld_cyc.size();
    run(2100, D00, D00, D00);
    run(6, C00, C00, C00);
    chk("l2100_writes", wr_addr.size() - wb, 512);
    chk("l2100_first_addr", wa(wb), 10'h200);
    chk("l2100_last_addr", wa(wb + 511), 10'h3FF);
    chk("l2100_done_cnt", ld_cyc.size() - lb, 1);
    chk("l2100_len", ll(lb), 11'd2047);

    // Reset mid-line at pixel 100.
    run(100, D00, D00, D00);
    reset_n = 1'b0;
    #1;
    chk("mrst_flags", {h_sync, v_sync, de, l_wen, line_done, frame_start}, 0);
    chk("mrst_addr", l_wraddr, 10'h000);
    chk("mrst_len", line_len, 11'd0);
    chk("mrst_err", err_count, 8'd0);
    wb = wr_addr.size();
    lb = ld_cyc.size();
    run(2, D00, D00, D00);
    reset_n = 1'b1;
    run(20, D00, D00, D00);
    run(4, C00, C00, C00);
    chk("mrst_no_wen", wr_addr.size() - wb, 0);
    chk("mrst_no_done", ld_cyc.size() - lb, 0);
    run(12, C00, C00, C00);
    run(4, D00, D00, D00);
    run(6, C00, C00, C00);
    chk("relock_writes", wr_addr.size() - wb, 1);
    chk("relock_addr", wa(wb), 10'h000);
    chk("relock_len", ll(lb), 11'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
